// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: binary-to-BCD shift-add-3 converter,
// atomic display buffer, digit scan and active-low segment font.
module fnd_scan_controller #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic [3:0]  i_dp_mask,
    output logic        o_busy,
    output logic [1:0]  o_digit_sel,
    output logic [3:0]  o_bcd,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [13:0]   pval_q, pval_d;
    logic [15:0]   buf_q, buf_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    font_q, font_d;
    logic [15:0]   adj;
    logic          tick;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg;

    function automatic logic [13:0] sat(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] font7(input logic [3:0] d);
        logic [6:0] f;
        case (d)
            4'd0:    f = 7'h40;
            4'd1:    f = 7'h79;
            4'd2:    f = 7'h24;
            4'd3:    f = 7'h30;
            4'd4:    f = 7'h19;
            4'd5:    f = 7'h12;
            4'd6:    f = 7'h02;
            4'd7:    f = 7'h78;
            4'd8:    f = 7'h00;
            4'd9:    f = 7'h10;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    assign adj = add3(acc_q);

    // A load arriving during COMMIT chains straight into the next conversion.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    bin_d   = sat(i_value);
                    acc_d   = '0;
                    cnt_d   = 4'd13;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {acc_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                if (cnt_q == 4'd0) state_d = S_COMMIT;
                else cnt_d = cnt_q - 4'd1;
                if (i_load) begin
                    pend_d = 1'b1;
                    pval_d = i_value;
                end
            end
            S_COMMIT: begin
                buf_d = acc_q;
                if (pend_q || i_load) begin
                    bin_d   = sat(i_load ? i_value : pval_q);
                    acc_d   = '0;
                    cnt_d   = 4'd13;
                    pend_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign idx_d = tick ? idx_q + 2'd1 : idx_q;

    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        case (idx_q)
            2'd0: nib = buf_q[3:0];
            2'd1: begin
                nib   = buf_q[7:4];
                blank = (buf_q[15:4] == 12'd0);
            end
            2'd2: begin
                nib   = buf_q[11:8];
                blank = (buf_q[15:8] == 8'd0);
            end
            default: begin
                nib   = buf_q[15:12];
                blank = (buf_q[15:12] == 4'd0);
            end
        endcase
        seg    = (BLANK_LZ && blank) ? 7'h7F : font7(nib);
        sel_d  = idx_q;
        bcd_d  = nib;
        com_d  = ~(4'b0001 << idx_q);
        font_d = {~i_dp_mask[idx_q], seg};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            buf_q   <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            bcd_q   <= '0;
            com_q   <= 4'b1110;
            font_q  <= 8'hC0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            buf_q   <= buf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
            com_q   <= com_d;
            font_q  <= font_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_digit_sel = sel_q;
    assign o_bcd       = bcd_q;
    assign o_fnd_com   = com_q;
    assign o_fnd_font  = font_q;

endmodule
